// File: rtl/nmr_bstrm_gate_drv.sv
// ---------------------------------------------------------------------------
// nmr_bstrm_gate_drv
//
// Converts the NMR bitstream sequencer's polarity stream and run status into
// the two non-overlapping H-bridge gate drives of the transmit coil driver.
// Every polarity change passes through a dead period with both gates low.
// A receiver enable opens after a programmable ring-down delay once the
// transmitter is off.
//
// Optional feature (compile-time macro NMR_GATE_DRV_PWFAULT_EN):
//   defined   - sticky FAULT flags polarity pulses that end while still in
//               the dead period (pulse shorter than the dead time).
//   undefined - FAULT is tied low; gate behaviour is unchanged.
//
// Parameters:
//   DT_WIDTH   width of the dead-time value
//   RD_WIDTH   width of the ring-down value
//
// Ports:
//   CLK        system clock, the only clock
//   RST        synchronous, active-high reset
//   BSTRM_IN   polarity bit: 1 selects leg P, 0 selects leg N
//   BSTRM_EN   high while the sequencer is running
//   DEADTIME   dead-time cycles (0 behaves as 1), static while BSTRM_EN high
//   RINGDOWN   cycles from both gates low to RX_EN
//   GATE_P     leg P gate drive
//   GATE_N     leg N gate drive
//   RX_EN      receiver enable
//   FAULT      sticky short-pulse fault
//
// States:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | transmitter off, gates low, ring-down counter running
//   ST_DEAD  | gates low, dead timer counting toward the latched target
//   ST_DRV_P | leg P driven
//   ST_DRV_N | leg N driven
// ---------------------------------------------------------------------------
module nmr_bstrm_gate_drv #(
    parameter int DT_WIDTH = 8,
    parameter int RD_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BSTRM_IN,
    input  logic                BSTRM_EN,
    input  logic [DT_WIDTH-1:0] DEADTIME,
    input  logic [RD_WIDTH-1:0] RINGDOWN,
    output logic                GATE_P,
    output logic                GATE_N,
    output logic                RX_EN,
    output logic                FAULT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRV_P = 2'd2,
        ST_DRV_N = 2'd3
    } state_t;

    localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);
    localparam logic [RD_WIDTH-1:0] RD_ONE = RD_WIDTH'(1);
    localparam logic [RD_WIDTH-1:0] RD_MAX = '1;

    state_t                state_q, state_d;
    logic                  in_q, en_q;
    logic [DT_WIDTH-1:0]   dt_cnt_q, dt_cnt_d;
    logic                  target_q, target_d;
    logic [RD_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic                  rx_en_q, rx_en_d;
    logic [DT_WIDTH-1:0]   dt_eff;

    // A programmed dead time of zero still gives one full cycle with both
    // gates low, so the legs can never overlap.
    assign dt_eff = (DEADTIME == '0) ? DT_ONE : DEADTIME;

    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        target_d = target_q;
        rd_cnt_d = rd_cnt_q;

        if (!en_q) begin
            // Transmitter off always wins. The ring-down count restarts on
            // the edge that enters IDLE and saturates while staying there.
            state_d = ST_IDLE;
            if (state_q == ST_IDLE) begin
                rd_cnt_d = (rd_cnt_q == RD_MAX) ? rd_cnt_q : rd_cnt_q + RD_ONE;
            end else begin
                rd_cnt_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_DEAD;
                    dt_cnt_d = dt_eff;
                    target_d = in_q;
                    rd_cnt_d = '0;
                end
                ST_DEAD: begin
                    // A polarity change during the dead period restarts it;
                    // this takes priority over timer expiry so a pulse that
                    // ends on the last dead cycle never reaches a gate.
                    if (in_q != target_q) begin
                        target_d = in_q;
                        dt_cnt_d = dt_eff;
                    end else if (dt_cnt_q <= DT_ONE) begin
                        state_d = target_q ? ST_DRV_P : ST_DRV_N;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_ONE;
                    end
                end
                ST_DRV_P: begin
                    if (!in_q) begin
                        state_d  = ST_DEAD;
                        dt_cnt_d = dt_eff;
                        target_d = 1'b0;
                    end
                end
                ST_DRV_N: begin
                    if (in_q) begin
                        state_d  = ST_DEAD;
                        dt_cnt_d = dt_eff;
                        target_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Registered so that RX_EN is low during and right after reset,
        // while keeping the same edge as a decode of the next state.
        rx_en_d = (state_d == ST_IDLE) && (rd_cnt_d >= RINGDOWN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            in_q     <= 1'b0;
            en_q     <= 1'b0;
            dt_cnt_q <= '0;
            target_q <= 1'b0;
            rd_cnt_q <= '0;
            rx_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_q     <= BSTRM_IN;
            en_q     <= BSTRM_EN;
            dt_cnt_q <= dt_cnt_d;
            target_q <= target_d;
            rd_cnt_q <= rd_cnt_d;
            rx_en_q  <= rx_en_d;
        end
    end

    // Gates are pure decodes of the registered state: only one of the two
    // states can be active, so the legs are exclusive by construction.
    assign GATE_P = (state_q == ST_DRV_P);
    assign GATE_N = (state_q == ST_DRV_N);
    assign RX_EN  = rx_en_q;

`ifdef NMR_GATE_DRV_PWFAULT_EN
    logic fault_q, fault_d;

    // Set when the polarity flips again before the dead period ends;
    // cleared only by reset or by the start of a new sequence.
    always_comb begin
        fault_d = fault_q;
        if (en_q && (state_q == ST_IDLE)) begin
            fault_d = 1'b0;
        end else if (en_q && (state_q == ST_DEAD) && (in_q != target_q)) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign FAULT = fault_q;
`else
    assign FAULT = 1'b0;
`endif

endmodule

// File: doc/nmr_bstrm_gate_drv.md
# nmr_bstrm_gate_drv

Downstream stage of the NMR bitstream sequencer: consumes its single-bit pulse-polarity stream (`OUT`) and its running/done status, and converts them into the two non-overlapping H-bridge gate drives of the transmit coil driver. Enforces a programmable dead time between legs and generates a receiver-enable gate that opens only after a programmable ring-down delay once transmission has stopped. An optional sticky fault flags polarity pulses shorter than the dead time.

## Interface
- `DT_WIDTH`, default 8: width of the dead-time value.
- `RD_WIDTH`, default 16: width of the ring-down value.
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `BSTRM_IN`  in  1  polarity bit from the sequencer `OUT`; 1 selects leg P, 0 selects leg N.
- `BSTRM_EN`  in  1  high while the sequencer is running (`START` to `DONE`); low means transmitter off.
- `DEADTIME`  in  `DT_WIDTH`  dead-time cycles; 0 is treated as 1; held static while `BSTRM_EN` is high.
- `RINGDOWN`  in  `RD_WIDTH`  cycles from both gates low to `RX_EN`; held static while in IDLE countdown.
- `GATE_P`  out  1  leg P gate drive.
- `GATE_N`  out  1  leg N gate drive.
- `RX_EN`  out  1  receiver enable.
- `FAULT`  out  1  sticky short-pulse fault.

## Operation
- Input register: `BSTRM_IN`, `BSTRM_EN` → `in_q`, `en_q` (one stage, same edge); the FSM uses only the registered copies.
- States: IDLE, DEAD, DRV_P, DRV_N. Outputs decoded from state: `GATE_P` = (state == DRV_P), `GATE_N` = (state == DRV_N). Both are never high together, in any state, after reset, or on any transition.
- IDLE: gates low; ring-down counter counts up and saturates; `RX_EN` = (count ≥ `RINGDOWN`). On `en_q`=1 → DEAD, load dead timer, latch target = `in_q`, clear ring-down counter, and drop `RX_EN`.
- DEAD: gates low; dead timer decrements. If `in_q` differs from the latched target, re-latch the target, reload the timer, and set `FAULT`. When the timer expires, go to DRV_P (target 1) or DRV_N (target 0).
- DRV_P / DRV_N: when `in_q` differs from the driven leg → DEAD with timer reload and target = `in_q`. No direct DRV_P↔DRV_N path exists.
- Any state with `en_q`=0 → IDLE on the next edge; gates fall immediately and the ring-down counter restarts at 0. This is the only exit to IDLE.
- `FAULT` clears on `RST` or when entering DEAD from IDLE (new sequence).
- Arithmetic: the dead timer is `DT_WIDTH` bits; the effective dead time is max(`DEADTIME`,1) cycles. The ring-down counter is `RD_WIDTH` bits, saturating (no wrap).
- Reset: state IDLE, `GATE_P`=0, `GATE_N`=0, `RX_EN`=0, `FAULT`=0, counters 0. `RX_EN` rises `RINGDOWN` cycles after reset release. Reset mid-drive drops gates on the reset edge.

## Timing
- Edge numbering: the input changes before edge k and is sampled at edge k.
- Gate fall: 2 edges after the input change (edge k+1), both for a polarity change and for `BSTRM_EN` falling.
- Gate rise on the opposite leg: edge k+1+max(`DEADTIME`,1), so exactly max(`DEADTIME`,1) cycles with both gates low.
- First gate after `BSTRM_EN` rises: same rule. `RX_EN` falls at edge k+1, at least one dead period before any gate rises.
- `RX_EN` rise: `RINGDOWN` edges after entering IDLE; `RINGDOWN`=0 asserts it in the first IDLE cycle.
- A pulse of length L < effective dead time is absorbed: no gate pulse is produced and `FAULT` is set.

## Configuration
- `NMR_GATE_DRV_PWFAULT_EN` defined: short-pulse detection and the sticky `FAULT` are implemented as described.
- Not defined: `FAULT` is tied to 0 and the detection logic is removed. DEAD still re-latches the target and reloads the timer on a polarity change, so gate behaviour is identical.

## Test plan
- Reset with `RINGDOWN`=5: after `RST` falls, gates stay 0 and `RX_EN` rises exactly 5 cycles later; `FAULT`=0.
- `DEADTIME`=3, `BSTRM_EN`↑ with `BSTRM_IN`=1: `RX_EN` falls at k+1 and `GATE_P` rises at k+4. `BSTRM_IN`→0 after 10 cycles: `GATE_P` falls at k+1, `GATE_N` rises at k+4, with 3 cycles of both low.
- `DEADTIME`=4, polarity pulse of 2 cycles in the middle of DRV_N: no `GATE_P` pulse, `GATE_N` resumes 4 cycles after the last change, `FAULT`=1 and stays 1 until the next sequence start.
- `BSTRM_EN`↓ during DRV_P with `RINGDOWN`=8: `GATE_P` falls 2 edges after the input edge, and `RX_EN` rises 8 cycles after that.
- `DEADTIME`=0: both-low gap is exactly 1 cycle. Assert `RST` mid-DRV_N: `GATE_N` falls at the reset edge, then `RX_EN` rises `RINGDOWN` cycles after reset release.
